// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver:
// parity selectors, FSM state encoding and the sample-tick divider helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  // Clocks per oversample tick, truncated toward zero.
  function automatic int calc_ticks(input int clk, input int baud, input int os);
    return clk / (baud * os);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Byte-output handshake between the UART receiver and its consumer,
// plus the receiver's status pulses.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);

  logic                 i_rx_ready;
  logic [DATA_BITS-1:0] o_rx_data;
  logic                 o_rx_valid;
  logic                 o_parity_err;
  logic                 o_frame_err;
  logic                 o_break;
  logic                 o_overrun;
  logic                 o_rx_busy;

  // Receiver side.
  modport master (
    input  i_rx_ready,
    output o_rx_data,
    output o_rx_valid,
    output o_parity_err,
    output o_frame_err,
    output o_break,
    output o_overrun,
    output o_rx_busy
  );

  // Consumer side.
  modport slave (
    output i_rx_ready,
    input  o_rx_data,
    input  o_rx_valid,
    input  o_parity_err,
    input  o_frame_err,
    input  o_break,
    input  o_overrun,
    input  o_rx_busy
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Restartable oversample divider: one-cycle tick every TICKS clocks and a
// sample counter that runs 0..OVERSAMPLE-1 within each bit.
module uart_baud_tick #(
  parameter int TICKS      = 27,
  parameter int OVERSAMPLE = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_restart,
  output logic                          o_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] o_sample_cnt
);

  localparam int TW = $clog2(TICKS);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);
  localparam logic [SW-1:0] SMP_LAST  = SW'(OVERSAMPLE - 1);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [SW-1:0] smp_cnt_q, smp_cnt_d;

  assign o_tick       = (tick_cnt_q == TICK_LAST) && !i_restart;
  assign o_sample_cnt = smp_cnt_q;

  always_comb begin
    // NOTE: every _d signal gets its default first so no latch is inferred.
    tick_cnt_d = tick_cnt_q;
    smp_cnt_d  = smp_cnt_q;
    if (i_restart) begin
      tick_cnt_d = '0;
      smp_cnt_d  = '0;
    end else if (o_tick) begin
      tick_cnt_d = '0;
      smp_cnt_d  = (smp_cnt_q == SMP_LAST) ? '0 : smp_cnt_q + 1'b1;
    end else begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: state registers take non-blocking assignments only.
    if (!i_rst_n) begin
      tick_cnt_q <= '0;
      smp_cnt_q  <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      smp_cnt_q  <= smp_cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-FF synchroniser, oversampled 3-sample vote,
// framing FSM, error/break detection and a valid/ready holding register.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_rx_serial,
  uart_rx_cfg_if.master rx_if
);

  localparam int TICKS = calc_ticks(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int SW    = $clog2(OVERSAMPLE);
  localparam int BW    = $clog2(DATA_BITS + 1);
  localparam int M     = OVERSAMPLE / 2;

  localparam logic [SW-1:0] CNT_LO    = SW'(M - 1);
  localparam logic [SW-1:0] CNT_MID   = SW'(M);
  localparam logic [SW-1:0] CNT_HI    = SW'(M + 1);
  localparam logic [SW-1:0] CNT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  if (TICKS < 2) begin : g_bad_ticks
    $error("uart_rx_cfg: CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("uart_rx_cfg: OVERSAMPLE must be even and at least 8");
  end

  logic [1:0]           sync_q;
  rx_state_e            state_q, state_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           samp_q, samp_d;
  logic                 par_bit_q, par_bit_d;
  logic                 perr_w_q, perr_w_d;
  logic                 ferr_w_q, ferr_w_d;
  logic                 busy_q, busy_d;

  logic                 valid_q, valid_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 brk_q, brk_d;
  logic                 ovr_q, ovr_d;

  logic          rx_s;
  logic          restart;
  logic          tick;
  logic [SW-1:0] smp_cnt;
  logic          vote;
  logic          vote_done;
  logic          boundary;
  logic          exp_par;
  logic          complete;
  logic          frame_err_now;
  logic          is_break;
  logic          accept;

  uart_baud_tick #(
    .TICKS      (TICKS),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud_tick (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_restart    (restart),
    .o_tick       (tick),
    .o_sample_cnt (smp_cnt)
  );

  assign rx_s      = sync_q[1];
  assign vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
  assign vote_done = tick && (smp_cnt == CNT_HI);
  assign boundary  = tick && (smp_cnt == CNT_LAST);
  assign exp_par   = (PARITY == PAR_ODD) ? ~(^shift_q) : (^shift_q);
  assign accept    = valid_q && rx_if.i_rx_ready;

  // Only the first stop bit decides framing; a second stop bit is checked for line level only.
  assign frame_err_now = (stop_idx_q == 1'b0) ? !vote : ferr_w_q;
  assign is_break      = frame_err_now && (shift_q == '0) && ((PARITY == PAR_NONE) || !par_bit_q);

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    samp_d     = samp_q;
    par_bit_d  = par_bit_q;
    perr_w_d   = perr_w_q;
    ferr_w_d   = ferr_w_q;
    restart    = 1'b0;
    complete   = 1'b0;

    if (tick && smp_cnt == CNT_LO)  samp_d[0] = rx_s;
    if (tick && smp_cnt == CNT_MID) samp_d[1] = rx_s;

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d    = ST_START;
          restart    = 1'b1;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          par_bit_d  = 1'b0;
          perr_w_d   = 1'b0;
          ferr_w_d   = 1'b0;
        end
      end
      ST_START: begin
        if (vote_done && vote)  state_d = ST_IDLE;
        else if (boundary)      state_d = ST_DATA;
      end
      ST_DATA: begin
        if (vote_done) begin
          shift_d   = {vote, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 1'b1;
        end
        if (boundary && bit_idx_q == IDX_LAST)
          state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (vote_done) begin
          par_bit_d = vote;
          perr_w_d  = (vote != exp_par);
        end
        if (boundary) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (vote_done) begin
          ferr_w_d = frame_err_now;
          if (stop_idx_q == STOP_LAST) begin
            complete = 1'b1;
            state_d  = vote ? ST_IDLE : ST_WAIT_IDLE;
          end
        end else if (boundary) begin
          stop_idx_d = 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A completed frame is accepted if the holder is free or being emptied this cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    brk_d   = 1'b0;
    ovr_d   = 1'b0;
    busy_d  = (state_q != ST_IDLE);
    if (complete) begin
      brk_d = is_break;
      if (!valid_q || accept) begin
        valid_d = 1'b1;
        data_d  = shift_q;
        perr_d  = perr_w_q;
        ferr_d  = frame_err_now;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q     <= 2'b11;
      state_q    <= ST_IDLE;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      samp_q     <= 2'b11;
      par_bit_q  <= 1'b0;
      perr_w_q   <= 1'b0;
      ferr_w_q   <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], i_rx_serial};
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      samp_q     <= samp_d;
      par_bit_q  <= par_bit_d;
      perr_w_q   <= perr_w_d;
      ferr_w_q   <= ferr_w_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_if.o_rx_data    = data_q;
  assign rx_if.o_rx_valid   = valid_q;
  assign rx_if.o_parity_err = perr_q;
  assign rx_if.o_frame_err  = ferr_q;
  assign rx_if.o_break      = brk_q;
  assign rx_if.o_overrun    = ovr_q;
  assign rx_if.o_rx_busy    = busy_q;

endmodule
